// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl - main control FSM for the multi-cycle RV32I core.
// Each instruction is sequenced through fetch, decode, execute, memory and
// writeback. The Avalon-MM instruction and data masters are handshaked here:
// reads are pipelined (request accepted, then readdatavalid), writes are held
// until waitrequest drops. Bus phases that stall too long trap with BUS_ERR.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   HALT                hold before the next fetch (sampled in IDLE only)
//   OPCODE              IR[6:0] of the current instruction
//   BR_TAKEN            branch compare result, used in EXECUTE
//   I_/D_WAITREQUEST    Avalon-MM request stall
//   I_/D_READDATAVALID  Avalon-MM read data return
//   I_READ, D_READ, D_WRITE    bus requests
//   IR_LOAD, MDR_LOAD          instruction / load-data capture strobes
//   PC_WRITE, PC_SRC           PC enable and next-PC select
//   ALUOP, ALUSRC_A, ALUSRC_B  ALU class code and operand selects
//   REG_WRITE, WB_SEL          register-file write enable and source
//   ILLEGAL, BUS_ERR           sticky trap flags
//   BUSY                       high outside IDLE and TRAP
module rv_mc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       HALT,
  input  logic [6:0] OPCODE,
  input  logic       BR_TAKEN,
  input  logic       I_WAITREQUEST,
  input  logic       I_READDATAVALID,
  input  logic       D_WAITREQUEST,
  input  logic       D_READDATAVALID,
  output logic       I_READ,
  output logic       D_READ,
  output logic       D_WRITE,
  output logic       IR_LOAD,
  output logic       MDR_LOAD,
  output logic       PC_WRITE,
  output logic [1:0] PC_SRC,
  output logic [1:0] ALUOP,
  output logic       ALUSRC_A,
  output logic [1:0] ALUSRC_B,
  output logic       REG_WRITE,
  output logic [1:0] WB_SEL,
  output logic       ILLEGAL,
  output logic       BUS_ERR,
  output logic       BUSY
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_FETCH_REQ  = 4'd1;
  localparam logic [3:0] S_FETCH_WAIT = 4'd2;
  localparam logic [3:0] S_DECODE     = 4'd3;
  localparam logic [3:0] S_EXECUTE    = 4'd4;
  localparam logic [3:0] S_MEM_REQ    = 4'd5;
  localparam logic [3:0] S_MEM_WAIT   = 4'd6;
  localparam logic [3:0] S_WRITEBACK  = 4'd7;
  localparam logic [3:0] S_TRAP       = 4'd8;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;
  logic             r_bus_err;

  logic w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store, w_opimm, w_op;
  logic w_legal;
  logic w_phase;     // in a bus REQ or WAIT state
  logic w_done;      // current bus phase completes this cycle
  logic w_last;      // counter has reached the stall limit

  assign w_lui    = (OPCODE == 7'b0110111);
  assign w_auipc  = (OPCODE == 7'b0010111);
  assign w_jal    = (OPCODE == 7'b1101111);
  assign w_jalr   = (OPCODE == 7'b1100111);
  assign w_branch = (OPCODE == 7'b1100011);
  assign w_load   = (OPCODE == 7'b0000011);
  assign w_store  = (OPCODE == 7'b0100011);
  assign w_opimm  = (OPCODE == 7'b0010011);
  assign w_op     = (OPCODE == 7'b0110011);
  assign w_legal  = w_lui | w_auipc | w_jal | w_jalr | w_branch |
                    w_load | w_store | w_opimm | w_op;

  always_comb begin
    w_phase = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_FETCH_REQ:  begin w_phase = 1'b1; w_done = !I_WAITREQUEST;   end
      S_FETCH_WAIT: begin w_phase = 1'b1; w_done = I_READDATAVALID;  end
      S_MEM_REQ:    begin w_phase = 1'b1; w_done = !D_WAITREQUEST;   end
      S_MEM_WAIT:   begin w_phase = 1'b1; w_done = D_READDATAVALID;  end
      default:      ;
    endcase
  end

  assign w_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (!HALT) w_next = S_FETCH_REQ;
      S_FETCH_REQ:  if (w_done) w_next = S_FETCH_WAIT;
                    else if (w_last) w_next = S_TRAP;
      S_FETCH_WAIT: if (w_done) w_next = S_DECODE;
                    else if (w_last) w_next = S_TRAP;
      S_DECODE:     w_next = w_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE:    if (w_branch) w_next = S_IDLE;
                    else if (w_load || w_store) w_next = S_MEM_REQ;
                    else w_next = S_WRITEBACK;
      S_MEM_REQ:    if (w_done) w_next = w_load ? S_MEM_WAIT : S_WRITEBACK;
                    else if (w_last) w_next = S_TRAP;
      S_MEM_WAIT:   if (w_done) w_next = S_WRITEBACK;
                    else if (w_last) w_next = S_TRAP;
      S_WRITEBACK:  w_next = S_IDLE;
      S_TRAP:       w_next = S_TRAP;
      default:      w_next = S_IDLE;
    endcase
  end

  // Counter restarts on every state change, so each REQ/WAIT phase starts
  // from zero; completion is checked before the limit, giving it precedence.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_phase)      r_cnt <= r_cnt + 1'b1;
      if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
      if (w_phase && !w_done && w_last)    r_bus_err <= 1'b1;
    end
  end

  assign ILLEGAL = r_illegal;
  assign BUS_ERR = r_bus_err;
  assign BUSY    = (r_state != S_IDLE) && (r_state != S_TRAP);

  always_comb begin
    I_READ    = 1'b0;
    D_READ    = 1'b0;
    D_WRITE   = 1'b0;
    IR_LOAD   = 1'b0;
    MDR_LOAD  = 1'b0;
    PC_WRITE  = 1'b0;
    PC_SRC    = 2'b00;
    ALUOP     = 2'b00;
    ALUSRC_A  = 1'b0;
    ALUSRC_B  = 2'b00;
    REG_WRITE = 1'b0;
    WB_SEL    = 2'b00;
    case (r_state)
      S_FETCH_REQ:  I_READ  = 1'b1;
      S_FETCH_WAIT: IR_LOAD = I_READDATAVALID;
      S_EXECUTE: begin
        if (w_opimm) begin
          ALUSRC_B = 2'b01;
        end else if (w_lui || w_auipc) begin
          ALUOP    = 2'b01;
          ALUSRC_A = w_auipc;
          ALUSRC_B = 2'b01;
        end else if (w_load || w_store || w_jalr) begin
          ALUOP    = 2'b10;
          ALUSRC_B = 2'b01;
        end else if (w_jal) begin
          ALUOP    = 2'b10;
          ALUSRC_A = 1'b1;
          ALUSRC_B = 2'b10;
        end else if (w_branch) begin
          ALUOP    = 2'b11;
          PC_WRITE = 1'b1;
          PC_SRC   = BR_TAKEN ? 2'b01 : 2'b00;
        end
      end
      S_MEM_REQ: begin
        D_READ   = w_load;
        D_WRITE  = w_store;
        ALUOP    = 2'b10;
        ALUSRC_B = 2'b01;
      end
      S_MEM_WAIT: MDR_LOAD = D_READDATAVALID;
      S_WRITEBACK: begin
        REG_WRITE = !w_store;
        WB_SEL    = w_load ? 2'b01 : ((w_jal || w_jalr) ? 2'b10 : 2'b00);
        PC_WRITE  = 1'b1;
        PC_SRC    = w_jal ? 2'b01 : (w_jalr ? 2'b10 : 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Testbench for rv_mc_ctrl. Directed per-cycle vectors: each stimulus step
// pushes the hand-computed output word for that cycle into a scoreboard
// queue; a monitor pops and compares at the falling edge.
module tb_rv_mc_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       HALT = 1'b1;
  logic [6:0] OPCODE = 7'h33;
  logic       BR_TAKEN = 1'b0;
  logic       I_WAITREQUEST = 1'b0, I_READDATAVALID = 1'b0;
  logic       D_WAITREQUEST = 1'b0, D_READDATAVALID = 1'b0;
  logic       I_READ, D_READ, D_WRITE, IR_LOAD, MDR_LOAD, PC_WRITE;
  logic [1:0] PC_SRC, ALUOP, ALUSRC_B, WB_SEL;
  logic       ALUSRC_A, REG_WRITE, ILLEGAL, BUS_ERR, BUSY;

  rv_mc_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .HALT(HALT), .OPCODE(OPCODE), .BR_TAKEN(BR_TAKEN),
    .I_WAITREQUEST(I_WAITREQUEST), .I_READDATAVALID(I_READDATAVALID),
    .D_WAITREQUEST(D_WAITREQUEST), .D_READDATAVALID(D_READDATAVALID),
    .I_READ(I_READ), .D_READ(D_READ), .D_WRITE(D_WRITE),
    .IR_LOAD(IR_LOAD), .MDR_LOAD(MDR_LOAD), .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC),
    .ALUOP(ALUOP), .ALUSRC_A(ALUSRC_A), .ALUSRC_B(ALUSRC_B),
    .REG_WRITE(REG_WRITE), .WB_SEL(WB_SEL),
    .ILLEGAL(ILLEGAL), .BUS_ERR(BUS_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Output word layout (bit 0 unused).
  localparam logic [19:0] BSY  = 20'd1 << 19;
  localparam logic [19:0] ILL  = 20'd1 << 18;
  localparam logic [19:0] BERR = 20'd1 << 17;
  localparam logic [19:0] IRD  = 20'd1 << 16;
  localparam logic [19:0] DRD  = 20'd1 << 15;
  localparam logic [19:0] DWR  = 20'd1 << 14;
  localparam logic [19:0] IRL  = 20'd1 << 13;
  localparam logic [19:0] MDRL = 20'd1 << 12;
  localparam logic [19:0] PCW  = 20'd1 << 11;
  localparam logic [19:0] PCSI = 20'd1 << 9;
  localparam logic [19:0] PCSJ = 20'd2 << 9;
  localparam logic [19:0] ALUI = 20'd1 << 7;
  localparam logic [19:0] ADD  = 20'd2 << 7;
  localparam logic [19:0] ABR  = 20'd3 << 7;
  localparam logic [19:0] SAP  = 20'd1 << 6;
  localparam logic [19:0] SBI  = 20'd1 << 4;
  localparam logic [19:0] SB4  = 20'd2 << 4;
  localparam logic [19:0] RW   = 20'd1 << 3;
  localparam logic [19:0] WBM  = 20'd1 << 1;
  localparam logic [19:0] WBP  = 20'd2 << 1;

  logic [19:0] w_obs;
  assign w_obs = {BUSY, ILLEGAL, BUS_ERR, I_READ, D_READ, D_WRITE, IR_LOAD,
                  MDR_LOAD, PC_WRITE, PC_SRC, ALUOP, ALUSRC_A, ALUSRC_B,
                  REG_WRITE, WB_SEL, 1'b0};

  typedef struct {
    logic [19:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Persistent inputs; applied at the start of each step.
  logic h_rst = 1'b0, h_halt = 1'b1;
  logic [6:0] h_op = 7'h33;

  task automatic cyc(input logic [19:0] e, input string tag,
                     input logic iwr = 1'b0, input logic irdv = 1'b0,
                     input logic dwr = 1'b0, input logic drdv = 1'b0,
                     input logic br = 1'b0);
    exp_t x;
    @(posedge CLK);
    #1;
    RST_N = h_rst; HALT = h_halt; OPCODE = h_op; BR_TAKEN = br;
    I_WAITREQUEST = iwr; I_READDATAVALID = irdv;
    D_WAITREQUEST = dwr; D_READDATAVALID = drdv;
    x.v = e; x.tag = tag;
    q.push_back(x);
  endtask

  // IDLE -> FETCH_REQ -> FETCH_WAIT (zero wait) -> DECODE
  task automatic fetch_dec(input string t);
    cyc(20'd0,   {t, "_idle"});
    cyc(BSY|IRD, {t, "_freq"});
    cyc(BSY|IRL, {t, "_fwait"}, 1'b0, 1'b1);
    cyc(BSY,     {t, "_dec"});
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        x = q.pop_front();
        n_checks++;
        if (w_obs !== x.v) begin
          n_fail++;
          $display("FAIL %s: got %05h expected %05h at %0t", x.tag, w_obs, x.v, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and HALT hold
    h_rst = 1'b0; h_halt = 1'b1; h_op = 7'h33;
    cyc(20'd0, "rst"); cyc(20'd0, "rst");
    h_rst = 1'b1;
    cyc(20'd0, "idle_halt"); cyc(20'd0, "idle_halt");

    // OP, zero wait: 6 cycles IDLE..WRITEBACK
    h_halt = 1'b0; h_op = 7'h33;
    fetch_dec("op");
    cyc(BSY, "op_ex");
    cyc(BSY|PCW|RW, "op_wb");
    h_halt = 1'b1;
    cyc(20'd0, "op_idle_halt");

    // LOAD, 3 waitrequest cycles, readdatavalid 2 cycles late
    h_halt = 1'b0; h_op = 7'h03;
    fetch_dec("ld");
    cyc(BSY|ADD|SBI, "ld_ex");
    repeat (3) cyc(BSY|DRD|ADD|SBI, "ld_mreq_stall", 1'b0, 1'b0, 1'b1);
    cyc(BSY|DRD|ADD|SBI, "ld_mreq_acc");
    repeat (2) cyc(BSY, "ld_mwait");
    cyc(BSY|MDRL, "ld_mwait_rdv", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(BSY|PCW|RW|WBM, "ld_wb");

    // BRANCH taken then not taken
    h_op = 7'h63;
    fetch_dec("bt");
    cyc(BSY|ABR|PCW|PCSI, "bt_ex", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch_dec("bn");
    cyc(BSY|ABR|PCW, "bn_ex");

    // STORE, zero wait
    h_op = 7'h23;
    fetch_dec("st");
    cyc(BSY|ADD|SBI, "st_ex");
    cyc(BSY|DWR|ADD|SBI, "st_mreq");
    cyc(BSY|PCW, "st_wb");

    // JAL with HALT raised mid-instruction
    h_op = 7'h6F;
    cyc(20'd0, "jal_idle");
    h_halt = 1'b1;
    cyc(BSY|IRD, "jal_freq");
    cyc(BSY|IRL, "jal_fwait", 1'b0, 1'b1);
    cyc(BSY, "jal_dec");
    cyc(BSY|ADD|SAP|SB4, "jal_ex");
    cyc(BSY|PCW|PCSI|RW|WBP, "jal_wb");
    cyc(20'd0, "jal_idle_halt");
    h_halt = 1'b0;

    // JALR
    h_op = 7'h67;
    fetch_dec("jalr");
    cyc(BSY|ADD|SBI, "jalr_ex");
    cyc(BSY|PCW|PCSJ|RW|WBP, "jalr_wb");

    // AUIPC and LUI
    h_op = 7'h17;
    fetch_dec("auipc");
    cyc(BSY|ALUI|SAP|SBI, "auipc_ex");
    cyc(BSY|PCW|RW, "auipc_wb");
    h_op = 7'h37;
    fetch_dec("lui");
    cyc(BSY|ALUI|SBI, "lui_ex");
    cyc(BSY|PCW|RW, "lui_wb");

    // OP-IMM: completion on the 4th (limit) cycle of both fetch phases;
    // readdatavalid during the acceptance cycle is ignored
    h_op = 7'h13;
    cyc(20'd0, "oi_idle");
    repeat (3) cyc(BSY|IRD, "oi_freq_stall", 1'b1);
    cyc(BSY|IRD, "oi_freq_acc", 1'b0, 1'b1);
    repeat (3) cyc(BSY, "oi_fwait");
    cyc(BSY|IRL, "oi_fwait_last", 1'b0, 1'b1);
    cyc(BSY, "oi_dec");
    cyc(BSY|SBI, "oi_ex");
    cyc(BSY|PCW|RW, "oi_wb");

    // Fetch timeout: readdatavalid never arrives
    h_op = 7'h33;
    cyc(20'd0, "to_idle");
    cyc(BSY|IRD, "to_freq");
    repeat (4) cyc(BSY, "to_fwait");
    repeat (2) cyc(BERR, "to_trap");
    h_rst = 1'b0;
    cyc(20'd0, "to_rst");
    h_rst = 1'b1;

    // Illegal opcode
    h_op = 7'h7F;
    fetch_dec("ill");
    repeat (3) cyc(ILL, "ill_trap");
    h_rst = 1'b0;
    cyc(20'd0, "ill_rst");
    h_rst = 1'b1;

    // Reset asserted mid-cycle while D_WRITE is held
    h_op = 7'h23;
    fetch_dec("rs");
    cyc(BSY|ADD|SBI, "rs_ex");
    cyc(BSY|DWR|ADD|SBI, "rs_mreq", 1'b0, 1'b0, 1'b1);
    h_rst = 1'b0;
    cyc(20'd0, "rs_rst", 1'b0, 1'b0, 1'b1);
    h_rst = 1'b1;
    cyc(20'd0, "rs_idle");
    cyc(BSY|IRD, "rs_freq");
    cyc(BSY|IRL, "rs_fwait", 1'b0, 1'b1);
    cyc(BSY, "rs_dec");
    cyc(BSY|ADD|SBI, "rs_ex2");
    cyc(BSY|DWR|ADD|SBI, "rs_mreq2");
    cyc(BSY|PCW, "rs_wb");
    h_halt = 1'b1;
    repeat (2) cyc(20'd0, "rs_idle_halt");

    // Drain the scoreboard (bounded)
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
